// File: rtl/ps2_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_rx_frame
//  Description : PS/2 serial frame receiver. Samples the data line on each
//                falling-edge tick of the PS/2 clock and assembles an
//                11-bit frame: start, DATA_BITS data bits LSB-first, odd
//                parity, stop. Delivers good bytes, error pulses and an
//                inter-bit timeout abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_frame #(
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fall_tick,
  input  logic                 data_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 timeout_err,
  output logic                 busy
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(DATA_BITS) + 1;

  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LAST_BIT    = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]     bit_cnt;
  logic [TIMER_W-1:0]   timer;
  logic                 parity_bit;

  // The limit is only acted on when no tick arrives in the same cycle,
  // so a tick landing exactly on the limit still advances the frame.
  logic timeout_hit;
  assign timeout_hit = (state != IDLE) && !fall_tick && (timer == TIMER_LIMIT);

  // Frame FSM with inter-bit timer; every output is a register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      timer       <= '0;
      parity_bit  <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;

      if (state == IDLE || fall_tick || timeout_hit) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end

      if (timeout_hit) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        busy        <= 1'b0;
        timeout_err <= 1'b1;
      end else if (fall_tick) begin
        case (state)
          IDLE: begin
            // A high level on a tick is not a start bit; stay put silently.
            if (!data_in) begin
              state   <= DATA;
              bit_cnt <= '0;
              busy    <= 1'b1;
            end
          end
          DATA: begin
            // Right shift so the first (LSB) bit ends up at bit 0.
            shift_reg <= {data_in, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            parity_bit <= data_in;
            state      <= STOP;
          end
          STOP: begin
            state   <= IDLE;
            bit_cnt <= '0;
            busy    <= 1'b0;
            // Bad stop bit outranks bad parity.
            if (!data_in) begin
              frame_err <= 1'b1;
            end else if ((^shift_reg ^ parity_bit) != 1'b1) begin
              parity_err <= 1'b1;
            end else begin
              data_out   <= shift_reg;
              data_valid <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_rx_frame
//  Description : Randomized self-checking bench for ps2_rx_frame against a
//                frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_frame;

  localparam int DATA_BITS      = 8;
  localparam int TIMEOUT_CYCLES = 64;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 fall_tick = 1'b0;
  logic                 data_in = 1'b1;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 timeout_err;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  // Reference state: last good byte and expected number of pulse cycles.
  logic [7:0] model_data = 8'h00;
  int exp_valid = 0, exp_perr = 0, exp_ferr = 0, exp_terr = 0;
  int seen_valid = 0, seen_perr = 0, seen_ferr = 0, seen_terr = 0;

  ps2_rx_frame #(
    .DATA_BITS     (DATA_BITS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fall_tick  (fall_tick),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Count every clock cycle each pulse output is high.
  always @(posedge clk) begin
    if (data_valid)  seen_valid++;
    if (parity_err)  seen_perr++;
    if (frame_err)   seen_ferr++;
    if (timeout_err) seen_terr++;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    check_value({tag, "_valid_cycles"}, seen_valid, exp_valid);
    check_value({tag, "_perr_cycles"},  seen_perr,  exp_perr);
    check_value({tag, "_ferr_cycles"},  seen_ferr,  exp_ferr);
    check_value({tag, "_terr_cycles"},  seen_terr,  exp_terr);
  endtask

  // Called at a negedge; presents one tick for one clock, returns at next negedge.
  task automatic tick(input logic d);
    fall_tick = 1'b1;
    data_in   = d;
    @(negedge clk);
    fall_tick = 1'b0;
    data_in   = 1'b1;
  endtask

  // Idle cycles with a wandering data line that must be ignored without ticks.
  task automatic wait_gap(input int n);
    repeat (n) begin
      data_in = 1'($urandom);
      @(negedge clk);
    end
    data_in = 1'b1;
  endtask

  // Sends one full frame with tick edges `gap` clocks apart and checks the
  // outcome predicted from the frame contents.
  task automatic send_frame(input string tag, input logic [7:0] b, input logic par,
                            input logic stp, input int gap);
    logic ferr, perr, good;
    ferr = !stp;
    perr = stp && ((^b ^ par) != 1'b1);
    good = !ferr && !perr;
    tick(1'b0);
    check_value({tag, "_busy_in_frame"}, busy, 1);
    for (int i = 0; i < 8; i++) begin
      wait_gap(gap - 1);
      tick(b[i]);
    end
    wait_gap(gap - 1);
    tick(par);
    wait_gap(gap - 1);
    tick(stp);
    if (good) begin
      model_data = b;
      exp_valid++;
    end
    if (perr) exp_perr++;
    if (ferr) exp_ferr++;
    check_value({tag, "_valid"},     data_valid, good);
    check_value({tag, "_parity_err"}, parity_err, perr);
    check_value({tag, "_frame_err"},  frame_err, ferr);
    check_value({tag, "_data_out"},   data_out, model_data);
    check_value({tag, "_busy_after"}, busy, 0);
    repeat (2) @(negedge clk);
    check_counts(tag);
  endtask

  initial begin
    int k;
    logic [7:0] b;
    logic par, stp;
    int kind;

    // Reset state.
    #12;
    check_value("reset_data_out", data_out, 0);
    check_value("reset_busy", busy, 0);
    check_value("reset_pulses", {data_valid, parity_err, frame_err, timeout_err}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed frames.
    send_frame("good_1c", 8'h1C, 1'b0, 1'b1, 20);
    send_frame("perr_1c", 8'h1C, 1'b1, 1'b1, 20);
    send_frame("ferr_f0", 8'hF0, 1'b1, 1'b0, 20);

    // Timeout: start plus three data bits, then silence.
    tick(1'b0);
    for (int i = 0; i < 3; i++) begin
      wait_gap(19);
      tick(1'($urandom));
    end
    k = 0;
    while (k < 200 && !timeout_err) begin
      @(negedge clk);
      k++;
    end
    exp_terr++;
    check_value("timeout_latency", k, TIMEOUT_CYCLES);
    check_value("timeout_busy", busy, 0);
    check_value("timeout_data_out", data_out, model_data);
    repeat (2) @(negedge clk);
    check_counts("timeout");
    send_frame("good_aa", 8'hAA, 1'b1, 1'b1, 20);

    // Tick exactly on the timeout limit must keep the frame alive.
    send_frame("gap_limit", 8'h3C, 1'b1, 1'b1, TIMEOUT_CYCLES);

    // Spurious high ticks in IDLE.
    repeat (3) begin
      tick(1'b1);
      wait_gap(5);
      check_value("spurious_busy", busy, 0);
    end
    check_counts("spurious");

    // Reset in the middle of a frame.
    tick(1'b0);
    for (int i = 0; i < 5; i++) begin
      wait_gap(9);
      tick(1'($urandom));
    end
    wait_gap(2);
    rst = 1'b0;
    #1;
    model_data = 8'h00;
    check_value("midrst_data_out", data_out, 0);
    check_value("midrst_busy", busy, 0);
    check_value("midrst_pulses", {data_valid, parity_err, frame_err, timeout_err}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_counts("midrst");
    send_frame("good_5a", 8'h5A, 1'b1, 1'b1, 15);

    // Randomized frames: good, bad parity, or bad stop.
    for (int n = 0; n < 12; n++) begin
      kind = $urandom_range(0, 2);
      b    = 8'($urandom);
      par  = ~(^b);
      stp  = 1'b1;
      if (kind == 1) par = ~par;
      if (kind == 2) begin
        stp = 1'b0;
        par = 1'($urandom);
      end
      send_frame("rand", b, par, stp, $urandom_range(2, TIMEOUT_CYCLES));
      wait_gap($urandom_range(1, 10));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
